aes_block_packer: RTL and testbench

AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

---
 rtl/aes_block_packer.sv | 128 ++++++++++++
 tb/tb_aes_block_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs 32-bit plaintext words into 128-bit AES blocks (first word in the MSBs).
// Optional macro AES_PACKER_BYTESWAP_EN byte-reverses each word before it is placed.
module aes_block_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [31:0]  word_in,
  input  logic         word_last,
  output logic         data_valid,
  input  logic         data_ready,
  output logic [127:0] dataOut,
  output logic         block_partial,
  output logic [31:0]  block_count
);

  function automatic logic [31:0] fmt_word(input logic [31:0] w);
`ifdef AES_PACKER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] place_word(input logic [127:0] blk,
                                              input logic [1:0]   slot,
                                              input logic [31:0]  w);
    logic [127:0] r;
    r = blk;
    case (slot)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  logic [127:0] asm_q, asm_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         pend_part_q, pend_part_d;
  logic [127:0] out_q, out_d;
  logic         out_vld_q, out_vld_d;
  logic         out_part_q, out_part_d;
  logic [31:0]  count_q, count_d;

  logic         accept;
  logic         handoff;
  logic         out_free;
  logic         closing;
  logic         close_part;
  logic [127:0] asm_w;

  always_comb begin
    accept      = word_valid && !pend_q;
    handoff     = out_vld_q && data_ready;
    out_free    = !out_vld_q || handoff;
    asm_w       = place_word(asm_q, cnt_q, fmt_word(word_in));
    closing     = accept && (word_last || (cnt_q == 2'd3));
    close_part  = word_last && (cnt_q != 2'd3);

    asm_d       = asm_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_part_d = pend_part_q;
    out_d       = out_q;
    out_vld_d   = out_vld_q && !handoff;
    out_part_d  = out_part_q;
    count_d     = handoff ? count_q + 32'd1 : count_q;

    // A pending block blocks new words; it moves to the output register on the hand-off edge.
    if (pend_q) begin
      if (handoff) begin
        out_d       = asm_q;
        out_vld_d   = 1'b1;
        out_part_d  = pend_part_q;
        pend_d      = 1'b0;
        pend_part_d = 1'b0;
        asm_d       = '0;
      end
    end else if (closing) begin
      cnt_d = 2'd0;
      if (out_free) begin
        out_d      = asm_w;
        out_vld_d  = 1'b1;
        out_part_d = close_part;
        asm_d      = '0;
      end else begin
        asm_d       = asm_w;
        pend_d      = 1'b1;
        pend_part_d = close_part;
      end
    end else if (accept) begin
      asm_d = asm_w;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      cnt_q       <= 2'd0;
      pend_q      <= 1'b0;
      pend_part_q <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      out_part_q  <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_part_q <= pend_part_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      out_part_q  <= out_part_d;
      count_q     <= count_d;
    end
  end

  assign word_ready    = !pend_q;
  assign data_valid    = out_vld_q;
  assign dataOut       = out_q;
  assign block_partial = out_part_q;
  assign block_count   = count_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_aes_block_packer;

  logic         clk;
  logic         rst;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_in;
  logic         word_last;
  logic         data_valid;
  logic         data_ready;
  logic [127:0] dataOut;
  logic         block_partial;
  logic [31:0]  block_count;

  aes_block_packer dut (
    .clk          (clk),
    .rst          (rst),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_in      (word_in),
    .word_last    (word_last),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .dataOut      (dataOut),
    .block_partial(block_partial),
    .block_count  (block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    bit           p;
  } blk_t;

  typedef struct {
    logic [127:0] words;
    int           n;
    bit           last;
    logic [127:0] exp_d;
    bit           exp_p;
  } vec_t;

  blk_t        mq[$];
  logic [31:0] cur[$];
  logic [31:0] mcount;
  int          passed;
  int          total;

  function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef AES_PACKER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] swap_words(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = fmt(x[32*k +: 32]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_model();
    chk("word_ready", word_ready, (mq.size() < 2));
    chk("data_valid", data_valid, (mq.size() > 0));
    chk("block_count", block_count, mcount);
    if (mq.size() > 0) begin
      chk("dataOut", dataOut, mq[0].d);
      chk("block_partial", block_partial, mq[0].p);
    end
  endtask

  // One clock: model decides transfers from pre-edge state, then outputs are compared after the edge.
  task automatic tick();
    bit   acc, hof, r;
    blk_t b;
    r   = rst;
    acc = word_valid && (mq.size() < 2);
    hof = (mq.size() > 0) && data_ready;
    @(posedge clk);
    if (r) begin
      mq.delete();
      cur.delete();
      mcount = 0;
    end else begin
      if (hof) begin
        void'(mq.pop_front());
        mcount = mcount + 1;
      end
      if (acc) begin
        cur.push_back(fmt(word_in));
        if (cur.size() == 4 || word_last) begin
          b.d = '0;
          for (int k = 0; k < cur.size(); k++) b.d[127-32*k -: 32] = cur[k];
          b.p = (cur.size() < 4);
          mq.push_back(b);
          cur.delete();
        end
      end
    end
    #1;
    check_model();
  endtask

  vec_t        vt[5];
  logic [127:0] b1, b2, c1;
  logic [31:0]  c0;
  int           pos[$];

  initial begin
    passed = 0; total = 0; mcount = 0;
    rst = 1'b1; word_valid = 1'b0; word_in = '0; word_last = 1'b0; data_ready = 1'b0;

    vt[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 4, 1'b0,
              128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0};
    vt[1] = '{128'hDEADBEEF_01234567_00000000_00000000, 2, 1'b1,
              128'hDEADBEEF_01234567_00000000_00000000, 1'b1};
    vt[2] = '{128'hCAFEF00D_00000000_00000000_00000000, 1, 1'b1,
              128'hCAFEF00D_00000000_00000000_00000000, 1'b1};
    vt[3] = '{128'h11111111_22222222_33333333_00000000, 3, 1'b1,
              128'h11111111_22222222_33333333_00000000, 1'b1};
    vt[4] = '{128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 4, 1'b1,
              128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_dataOut", dataOut, 128'd0);
    chk("reset_partial", block_partial, 1'b0);
    chk("reset_ready", word_ready, 1'b1);

    // Directed blocks with data_ready held high.
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c0 = block_count;
      for (int k = 0; k < vt[i].n; k++) begin
        word_in    = vt[i].words[127-32*k -: 32];
        word_valid = 1'b1;
        word_last  = vt[i].last && (k == vt[i].n - 1);
        tick();
      end
      word_valid = 1'b0;
      word_last  = 1'b0;
      chk("vec_valid", data_valid, 1'b1);
      chk("vec_data", dataOut, swap_words(vt[i].exp_d));
      chk("vec_partial", block_partial, vt[i].exp_p);
`ifdef AES_PACKER_BYTESWAP_EN
      if (i == 0) chk("byteswap_msw", dataOut[127:96], 32'h33221100);
`endif
      tick();
      chk("vec_count", block_count, c0 + 32'd1);
    end

    // Back-pressure: 8 words with data_ready low -> one held, one pending.
    tick();
    data_ready = 1'b0;
    b1 = 128'h10000001_10000002_10000003_10000004;
    b2 = 128'h10000005_10000006_10000007_10000008;
    c0 = block_count;
    for (int k = 0; k < 8; k++) begin
      word_in    = 32'h10000001 + k;
      word_valid = 1'b1;
      tick();
    end
    word_valid = 1'b0;
    chk("bp_ready_low", word_ready, 1'b0);
    chk("bp_valid", data_valid, 1'b1);
    chk("bp_first", dataOut, swap_words(b1));
    word_in = 32'hFFFF_FFFF;
    word_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold", dataOut, swap_words(b1));
    end
    word_valid = 1'b0;
    data_ready = 1'b1;
    tick();
    chk("bp_second", dataOut, swap_words(b2));
    chk("bp_ready_back", word_ready, 1'b1);
    tick();
    chk("bp_count", block_count, c0 + 32'd2);
    chk("bp_drained", data_valid, 1'b0);

    // Twelve back-to-back words at full throughput.
    for (int i = 0; i < 12; i++) begin
      word_in    = $urandom;
      word_valid = 1'b1;
      tick();
      chk("stream_ready", word_ready, 1'b1);
      if (data_valid) pos.push_back(i);
    end
    word_valid = 1'b0;
    tick();
    chk("stream_blocks", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("stream_pos0", pos[0], 3);
      chk("stream_pos1", pos[1], 7);
      chk("stream_pos2", pos[2], 11);
    end

    // Reset in the middle of a block discards it.
    for (int k = 0; k < 2; k++) begin
      word_in    = 32'hBAD0_0000 + k;
      word_valid = 1'b1;
      tick();
    end
    word_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_data", dataOut, 128'd0);
    chk("mid_rst_count", block_count, 32'd0);
    chk("mid_rst_ready", word_ready, 1'b1);
    c1 = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
    for (int k = 0; k < 4; k++) begin
      word_in    = 32'hAAAA0001 + k;
      word_valid = 1'b1;
      tick();
    end
    word_valid = 1'b0;
    chk("post_rst_data", dataOut, swap_words(c1));
    chk("post_rst_partial", block_partial, 1'b0);
    tick();
    chk("post_rst_count", block_count, 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      word_valid = ($urandom_range(0, 3) != 0);
      word_last  = ($urandom_range(0, 4) == 0);
      data_ready = ($urandom_range(0, 2) != 0);
      word_in    = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
